// File: rtl/gray_conv_arbiter_if.sv
// Bundle between the two requesters, the result consumer and the shared
// Gray-to-binary engine.
interface gray_conv_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic [WIDTH-1:0] gray0;
   logic             req1;
   logic [WIDTH-1:0] gray1;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] bin_out;
   logic             bin_id;
   logic             bin_valid;
   logic             bin_ack;
   logic             busy;

   modport master (
      output req0, gray0, req1, gray1, bin_ack,
      input  gnt0, gnt1, bin_out, bin_id, bin_valid, busy
   );

   modport slave (
      input  req0, gray0, req1, gray1, bin_ack,
      output gnt0, gnt1, bin_out, bin_id, bin_valid, busy
   );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared bit-serial Gray-to-binary converter for two requesters.
// The result is held, tagged with the requester ID, until the consumer acks.
module gray_conv_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   gray_conv_arbiter_if.slave   bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             id_q, id_d;
   logic             valid_q, valid_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             busy_q, busy_d;

   logic             serve0;
   logic             serve1;
   logic             new_bit;

   // Pointer only breaks ties; a lone request always wins.
   assign serve0  = bus.req0 & (~bus.req1 | ~ptr_q);
   assign serve1  = bus.req1 & (~bus.req0 |  ptr_q);
   assign new_bit = bin_q[0] ^ gray_q[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
         gray_q  <= '0;
         bin_q   <= '0;
         id_q    <= 1'b0;
         valid_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gray_q  <= gray_d;
         bin_q   <= bin_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gray_d  = gray_q;
      bin_d   = bin_q;
      id_d    = id_q;
      valid_d = valid_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (serve0 || serve1) begin
               gray_d  = serve1 ? bus.gray1 : bus.gray0;
               id_d    = serve1;
               bin_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               gnt0_d  = serve0;
               gnt1_d  = serve1;
               ptr_d   = serve0;
               state_d = CONV;
            end
         end
         CONV: begin
            // bin_q starts at zero, so the first bit is just the Gray MSB.
            bin_d  = {bin_q[WIDTH-2:0], new_bit};
            gray_d = {gray_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (bus.bin_ack) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.bin_out   = bin_q;
   assign bus.bin_id    = id_q;
   assign bus.bin_valid = valid_q;
   assign bus.busy      = busy_q;
endmodule
